// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// rtl/firebird7_in_gate1_tdr_pkg.sv - shared types and helpers for the gate1 19-bit IJTAG TDR
// Purpose: chain-length and parity helpers plus the select/data field layout of the TDR.
// Ports: none (package).
package firebird7_in_gate1_tdr_pkg;

  localparam int TDR_WIDTH    = 19;
  localparam int PARITY_MAX_W = 64;

  // Field layout of the non-parity part of the chain, MSB first.
  typedef struct packed {
    logic                 sel;
    logic [TDR_WIDTH-1:0] data;
  } tdr_fields_t;

  // Select bit plus data, plus one parity bit when parity protection is built in.
  function automatic int tdr_len(input int width, input bit parity_en);
    return parity_en ? width + 2 : width + 1;
  endfunction

  // Even-parity bit over a zero-extended vector.
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tdr_update_reg.sv
// rtl/firebird7_in_gate1_tdr_update_reg.sv - enabled update register with parameterised reset value
// Purpose: holds one field of the TDR update stage; loads i_d when i_en is high.
// Ports:
//   i_clk   - TDR clock, posedge
//   i_rst_n - asynchronous active-low reset, loads RESET_VAL
//   i_en    - load enable
//   i_d     - next value
//   o_q     - registered value
module firebird7_in_gate1_tdr_update_reg #(
  parameter int           W         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv - IJTAG TDR driving the IJTAG side of the 19-bit data mux
// Purpose: scan segment that captures the mux output and updates ijtag_data_in/ijtag_select.
// Optional feature macro: FIREBIRD7_IN_GATE1_TDR_PARITY_EN (adds an even-parity bit and sticky parity_error).
// Ports:
//   ijtag_tck     - TDR clock, all flops posedge
//   ijtag_reset   - asynchronous active-low reset
//   ijtag_sel     - segment select; when low the chain and update stage hold
//   ijtag_ce      - capture enable (wins over shift)
//   ijtag_se      - shift enable
//   ijtag_ue      - update enable
//   ijtag_si      - scan in, enters the chain MSB
//   ijtag_so      - scan out, chain LSB
//   data_out_fb   - mux output, capture source
//   ijtag_data_in - update-register data to the mux
//   ijtag_select  - update-register select to the mux (0 = functional path)
//   parity_error  - sticky update-parity error (constant 0 without the feature)
module firebird7_in_gate1_tessent_tdr_w19_ctl
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int               WIDTH        = 19,
  parameter logic [WIDTH-1:0] RESET_DATA   = '0,
  parameter logic             RESET_SELECT = 1'b0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] data_out_fb,
  output logic [WIDTH-1:0] ijtag_data_in,
  output logic             ijtag_select,
  output logic             parity_error
);

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int L = tdr_len(WIDTH, PARITY_EN);

  logic [L-1:0] r_sr;
  logic [L-1:0] w_capture;
  logic         w_upd_req;
  logic         w_upd_en;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  logic w_parity_ok;
  logic r_parity_error;

  assign w_capture   = {parity(PARITY_MAX_W'({ijtag_select, data_out_fb})), ijtag_select, data_out_fb};
  assign w_parity_ok = (r_sr[L-1] == parity(PARITY_MAX_W'(r_sr[WIDTH:0])));
  assign w_upd_en    = w_upd_req & w_parity_ok;

  // Sticky: a rejected update sets it; only a good update that returns the
  // mux to the functional path (select bit 0) clears it.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_parity_error <= 1'b0;
    end else if (w_upd_req && !w_parity_ok) begin
      r_parity_error <= 1'b1;
    end else if (w_upd_en && !r_sr[WIDTH]) begin
      r_parity_error <= 1'b0;
    end
  end

  assign parity_error = r_parity_error;
`else
  assign w_capture    = {ijtag_select, data_out_fb};
  assign w_upd_en     = w_upd_req;
  assign parity_error = 1'b0;
`endif

  assign w_upd_req = ijtag_sel & ijtag_ue;

  // Capture has priority over shift; ce and se together never shift.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sr <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) begin
        r_sr <= w_capture;
      end else if (ijtag_se) begin
        r_sr <= {ijtag_si, r_sr[L-1:1]};
      end
    end
  end

  assign ijtag_so = r_sr[0];

  // Update samples the pre-edge chain, so a coincident capture/shift does not leak in.
  firebird7_in_gate1_tdr_update_reg #(
    .W         (WIDTH),
    .RESET_VAL (RESET_DATA)
  ) u_data_reg (
    .i_clk   (ijtag_tck),
    .i_rst_n (ijtag_reset),
    .i_en    (w_upd_en),
    .i_d     (r_sr[WIDTH-1:0]),
    .o_q     (ijtag_data_in)
  );

  firebird7_in_gate1_tdr_update_reg #(
    .W         (1),
    .RESET_VAL (RESET_SELECT)
  ) u_select_reg (
    .i_clk   (ijtag_tck),
    .i_rst_n (ijtag_reset),
    .i_en    (w_upd_en),
    .i_d     (r_sr[WIDTH]),
    .o_q     (ijtag_select)
  );

endmodule
